bin_io_ctrl: RTL

BIN_IO_CTRL -- requirements
Module: bin_io_ctrl

---
 rtl/sat_bin_io_pkg.sv | 30 +++
 rtl/idx_onehot.sv | 21 ++
 rtl/bin_io_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sat_bin_io_pkg.sv
// rtl/sat_bin_io_pkg.sv - shared FSM states and state-word layout for bin_io_ctrl
package sat_bin_io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_ST,
        WR_ST,
        LD_C,
        RUN,
        WB_C,
        WB_ST,
        DONE
    } state_t;

    // Full state word: {lvl_states, vars_states}
    function automatic int state_width(input int nl, input int wl, input int nv, input int wv);
        return nl * wl + nv * wv;
    endfunction

    // vars_states occupy the low end of the state word
    function automatic int vars_offset();
        return 0;
    endfunction

    // lvl_states sit directly above the vars_states
    function automatic int lvl_offset(input int nv, input int wv);
        return nv * wv;
    endfunction

endpackage

// File: rtl/idx_onehot.sv
// rtl/idx_onehot.sv - clause index to one-hot row select
module idx_onehot #(
    parameter int N     = 8,
    parameter int IDX_W = 4
) (
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    localparam logic [N-1:0] ONE = N'(1);

    // Single hot bit at idx, all zero when not enabled
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = ONE << idx;
        end
    end

endmodule

// File: rtl/bin_io_ctrl.sv
// rtl/bin_io_ctrl.sv - moves one bin between clause/state memories and the engine
module bin_io_ctrl
    import sat_bin_io_pkg::*;
#(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start_i,
    input  logic [WIDTH_BIN_ID-1:0]                       bin_id_i,
    output logic                                          done_o,
    output logic                                          cmem_en_o,
    output logic                                          cmem_we_o,
    output logic [WIDTH_BIN_ID+$clog2(NUM_CLAUSES)-1:0]   cmem_addr_o,
    input  logic [2*NUM_VARS-1:0]                         cmem_rdata_i,
    output logic [2*NUM_VARS-1:0]                         cmem_wdata_o,
    output logic                                          smem_en_o,
    output logic                                          smem_we_o,
    output logic [WIDTH_BIN_ID-1:0]                       smem_addr_o,
    input  logic [state_width(NUM_LVLS, WIDTH_LVL_STATES, NUM_VARS, WIDTH_VAR_STATES)-1:0] smem_rdata_i,
    output logic [state_width(NUM_LVLS, WIDTH_LVL_STATES, NUM_VARS, WIDTH_VAR_STATES)-1:0] smem_wdata_o,
    output logic                                          start_core_o,
    input  logic                                          done_core_i,
    output logic [NUM_CLAUSES-1:0]                        wr_carray_o,
    output logic [NUM_CLAUSES-1:0]                        rd_carray_o,
    output logic [2*NUM_VARS-1:0]                         clause_o,
    input  logic [2*NUM_VARS-1:0]                         clause_i,
    output logic [NUM_VARS-1:0]                           wr_var_states_o,
    output logic [NUM_VARS*WIDTH_VAR_STATES-1:0]          vars_states_o,
    input  logic [NUM_VARS*WIDTH_VAR_STATES-1:0]          vars_states_i,
    output logic [NUM_LVLS-1:0]                           wr_lvl_states_o,
    output logic [NUM_LVLS*WIDTH_LVL_STATES-1:0]          lvl_states_o,
    input  logic [NUM_LVLS*WIDTH_LVL_STATES-1:0]          lvl_states_i
);

    localparam int IW = $clog2(NUM_CLAUSES);
    localparam int VW = NUM_VARS * WIDTH_VAR_STATES;
    localparam int LW = NUM_LVLS * WIDTH_LVL_STATES;
    localparam int VO = vars_offset();
    localparam int LO = lvl_offset(NUM_VARS, WIDTH_VAR_STATES);

    // LD_C runs one extra cycle to absorb the clause memory read latency
    localparam logic [IW:0] LD_LAST = (IW + 1)'(NUM_CLAUSES);
    localparam logic [IW:0] WB_LAST = (IW + 1)'(NUM_CLAUSES - 1);
    localparam logic [IW:0] CNT_ONE = (IW + 1)'(1);

    state_t                  state;
    state_t                  next_state;
    logic [WIDTH_BIN_ID-1:0] bin_q;
    logic [IW:0]             cnt;
    logic                    run_first;
    logic                    oh_en;
    logic [IW:0]             oh_sel;
    logic [NUM_CLAUSES-1:0]  oh_row;

    // In LD_C the engine row lags the memory read by one cycle, hence cnt-1
    assign oh_en  = ((state == LD_C) && (cnt != '0)) || (state == WB_C);
    assign oh_sel = (state == LD_C) ? (cnt - CNT_ONE) : cnt;

    idx_onehot #(
        .N     (NUM_CLAUSES),
        .IDX_W (IW + 1)
    ) u_idx_onehot (
        .en     (oh_en),
        .idx    (oh_sel),
        .onehot (oh_row)
    );

    // State register, latched bin, row counter and first-RUN-cycle flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bin_q     <= '0;
            cnt       <= '0;
            run_first <= 1'b0;
        end else begin
            state     <= next_state;
            run_first <= (state == LD_C) && (cnt == LD_LAST);
            if ((state == IDLE) && start_i) begin
                bin_q <= bin_id_i;
            end
            if (state == LD_C) begin
                cnt <= (cnt == LD_LAST) ? '0 : cnt + CNT_ONE;
            end else if (state == WB_C) begin
                cnt <= (cnt == WB_LAST) ? '0 : cnt + CNT_ONE;
            end else begin
                cnt <= '0;
            end
        end
    end

    // Next-state sequencing; engine done only counts after the start pulse
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_i) next_state = LD_ST;
            LD_ST:   next_state = WR_ST;
            WR_ST:   next_state = LD_C;
            LD_C:    if (cnt == LD_LAST) next_state = RUN;
            RUN:     if (done_core_i && !run_first) next_state = WB_C;
            WB_C:    if (cnt == WB_LAST) next_state = WB_ST;
            WB_ST:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode; everything is forced quiet while rst is high
    always_comb begin
        done_o          = 1'b0;
        cmem_en_o       = 1'b0;
        cmem_we_o       = 1'b0;
        cmem_addr_o     = '0;
        cmem_wdata_o    = '0;
        smem_en_o       = 1'b0;
        smem_we_o       = 1'b0;
        smem_addr_o     = '0;
        smem_wdata_o    = '0;
        start_core_o    = 1'b0;
        wr_carray_o     = '0;
        rd_carray_o     = '0;
        clause_o        = '0;
        wr_var_states_o = '0;
        vars_states_o   = '0;
        wr_lvl_states_o = '0;
        lvl_states_o    = '0;
        if (!rst) begin
            case (state)
                LD_ST: begin
                    smem_en_o   = 1'b1;
                    smem_addr_o = bin_q;
                end
                WR_ST: begin
                    wr_var_states_o = '1;
                    wr_lvl_states_o = '1;
                    vars_states_o   = smem_rdata_i[VO +: VW];
                    lvl_states_o    = smem_rdata_i[LO +: LW];
                end
                LD_C: begin
                    if (cnt != LD_LAST) begin
                        cmem_en_o   = 1'b1;
                        cmem_addr_o = {bin_q, cnt[IW-1:0]};
                    end
                    if (cnt != '0) begin
                        wr_carray_o = oh_row;
                        clause_o    = cmem_rdata_i;
                    end
                end
                RUN: begin
                    start_core_o = run_first;
                end
                WB_C: begin
                    rd_carray_o  = oh_row;
                    cmem_en_o    = 1'b1;
                    cmem_we_o    = 1'b1;
                    cmem_addr_o  = {bin_q, cnt[IW-1:0]};
                    cmem_wdata_o = clause_i;
                end
                WB_ST: begin
                    smem_en_o    = 1'b1;
                    smem_we_o    = 1'b1;
                    smem_addr_o  = bin_q;
                    smem_wdata_o = {lvl_states_i, vars_states_i};
                end
                DONE: begin
                    done_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
